// File: rtl/ps2_letter_decoder.sv
// PS/2 set-2 receiver: letter make codes -> char 1..26 strobe, Enter strobe, frame error strobe.
// Define PS2_REPEAT_FILTER_EN to suppress typematic repeats of the held letter.
module ps2_letter_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       i_clk,
  input  logic       i_resetn,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic [4:0] o_char,
  output logic       o_char_valid,
  output logic       o_enter,
  output logic       o_frame_err
);

  localparam int              WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_CHECK = 2'd2} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_clk_s1, r_clk_s2, r_clk_s3, r_dat_s1, r_dat_s2;
  logic [3:0]      r_cnt, w_cnt_nxt;
  logic [9:0]      r_shift, w_shift_nxt;
  logic            r_brk, w_brk_nxt, r_ext, w_ext_nxt;
  logic [WD_W-1:0] r_wdog, w_wdog_nxt;
  logic [4:0]      w_char_nxt;
  logic            w_char_vld_nxt, w_enter_nxt, w_ferr_nxt;
  logic            w_fall, w_good;
  logic [7:0]      w_byte;
  logic [4:0]      w_letter;
`ifdef PS2_REPEAT_FILTER_EN
  logic [4:0]      r_held, w_held_nxt;
`endif

  function automatic logic [4:0] letter_of(input logic [7:0] b);
    case (b)
      8'h1C: letter_of = 5'd1;   8'h32: letter_of = 5'd2;   8'h21: letter_of = 5'd3;
      8'h23: letter_of = 5'd4;   8'h24: letter_of = 5'd5;   8'h2B: letter_of = 5'd6;
      8'h34: letter_of = 5'd7;   8'h33: letter_of = 5'd8;   8'h43: letter_of = 5'd9;
      8'h3B: letter_of = 5'd10;  8'h42: letter_of = 5'd11;  8'h4B: letter_of = 5'd12;
      8'h3A: letter_of = 5'd13;  8'h31: letter_of = 5'd14;  8'h44: letter_of = 5'd15;
      8'h4D: letter_of = 5'd16;  8'h15: letter_of = 5'd17;  8'h2D: letter_of = 5'd18;
      8'h1B: letter_of = 5'd19;  8'h2C: letter_of = 5'd20;  8'h3C: letter_of = 5'd21;
      8'h2A: letter_of = 5'd22;  8'h1D: letter_of = 5'd23;  8'h22: letter_of = 5'd24;
      8'h35: letter_of = 5'd25;  8'h1A: letter_of = 5'd26;
      default: letter_of = 5'd0;
    endcase
  endfunction

  // Frame is shifted in from the top: after 10 edges [7:0]=data, [8]=parity, [9]=stop.
  assign w_fall   = r_clk_s3 & ~r_clk_s2;
  assign w_byte   = r_shift[7:0];
  assign w_good   = (^r_shift[8:0]) & r_shift[9];
  assign w_letter = letter_of(w_byte);

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_shift_nxt    = r_shift;
    w_brk_nxt      = r_brk;
    w_ext_nxt      = r_ext;
    w_wdog_nxt     = '0;
    w_char_nxt     = o_char;
    w_char_vld_nxt = 1'b0;
    w_enter_nxt    = 1'b0;
    w_ferr_nxt     = 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
    w_held_nxt     = r_held;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          if (!r_dat_s2) begin
            w_state_nxt = S_SHIFT;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_ferr_nxt = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        if (w_fall) begin
          w_shift_nxt = {r_dat_s2, r_shift[9:1]};
          if (r_cnt == 4'd9) w_state_nxt = S_CHECK;
          else               w_cnt_nxt   = r_cnt + 4'd1;
        end else if (r_wdog == WD_LAST) begin
          w_state_nxt = S_IDLE;
          w_brk_nxt   = 1'b0;
          w_ext_nxt   = 1'b0;
          w_ferr_nxt  = 1'b1;
        end else begin
          w_wdog_nxt = r_wdog + 1'b1;
        end
      end
      S_CHECK: begin
        w_state_nxt = S_IDLE;
        if (!w_good) begin
          w_brk_nxt  = 1'b0;
          w_ext_nxt  = 1'b0;
          w_ferr_nxt = 1'b1;
        end else if (w_byte == 8'hF0) begin
          w_brk_nxt = 1'b1;
        end else if (w_byte == 8'hE0) begin
          w_ext_nxt = 1'b1;
        end else if (r_brk || r_ext) begin
          w_brk_nxt = 1'b0;
          w_ext_nxt = 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
          if (r_brk && (w_letter != 5'd0) && (w_letter == r_held)) w_held_nxt = 5'd0;
`endif
        end else if (w_letter != 5'd0) begin
`ifdef PS2_REPEAT_FILTER_EN
          if (w_letter != r_held) begin
            w_char_nxt     = w_letter;
            w_char_vld_nxt = 1'b1;
            w_held_nxt     = w_letter;
          end
`else
          w_char_nxt     = w_letter;
          w_char_vld_nxt = 1'b1;
`endif
        end else if (w_byte == 8'h5A) begin
          w_enter_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_clk_s1     <= 1'b1;
      r_clk_s2     <= 1'b1;
      r_clk_s3     <= 1'b1;
      r_dat_s1     <= 1'b1;
      r_dat_s2     <= 1'b1;
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_shift      <= 10'd0;
      r_brk        <= 1'b0;
      r_ext        <= 1'b0;
      r_wdog       <= '0;
      o_char       <= 5'd0;
      o_char_valid <= 1'b0;
      o_enter      <= 1'b0;
      o_frame_err  <= 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
      r_held       <= 5'd0;
`endif
    end else begin
      r_clk_s1     <= i_ps2_clk;
      r_clk_s2     <= r_clk_s1;
      r_clk_s3     <= r_clk_s2;
      r_dat_s1     <= i_ps2_dat;
      r_dat_s2     <= r_dat_s1;
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_brk        <= w_brk_nxt;
      r_ext        <= w_ext_nxt;
      r_wdog       <= w_wdog_nxt;
      o_char       <= w_char_nxt;
      o_char_valid <= w_char_vld_nxt;
      o_enter      <= w_enter_nxt;
      o_frame_err  <= w_ferr_nxt;
`ifdef PS2_REPEAT_FILTER_EN
      r_held       <= w_held_nxt;
`endif
    end
  end

endmodule

// File: doc/ps2_letter_decoder.md
# ps2_letter_decoder

Receives PS/2 keyboard frames and converts set-2 scan codes for letters A–Z into the 5-bit letter codes (A=1 … Z=26) consumed by the datapath `char`/`guess` inputs. It also reports Enter presses. It is the producer end of the keyboard-to-datapath interface and sits between the board PS/2 pins and the game control/datapath. It handles the frame protocol, break/extended prefixes, and framing errors, and emits single-cycle strobes in the `clk` domain.

## Interface
- `TIMEOUT_CYCLES`, default 50000: `clk` cycles without a PS/2 falling edge, mid-frame, before the frame is aborted (1 ms at 50 MHz).
- `clk` input 1: system clock; all logic is on the rising edge.
- `resetn` input 1: reset, synchronous and active-low.
- `ps2_clk` input 1: raw PS/2 clock pin, asynchronous.
- `ps2_dat` input 1: raw PS/2 data pin, asynchronous.
- `char` output 5: letter code 1–26; holds the last valid letter.
- `char_valid` output 1: one-cycle strobe when `char` is updated.
- `enter` output 1: one-cycle strobe on an Enter make code (0x5A).
- `frame_err` output 1: one-cycle strobe on a rejected or aborted frame.

## Operation
- Synchronisation:
  - `ps2_clk` and `ps2_dat` each pass through 2 flops.
  - A third flop on clock detects a falling edge (previous 1, current 0).
  - The data bit is sampled on the detected edge.
- Frame format: start bit (0), 8 data bits LSB first, odd parity bit, stop bit (1). 11 edges per frame.
- State machine:
  - IDLE: on a falling edge with data 0, go to SHIFT with bit count 0. On an edge with data 1, stay in IDLE and pulse `frame_err`.
  - SHIFT: shift in data bits 0–7, then the parity bit, then the stop bit. Bit count runs 0..9. The edge carrying the stop bit goes to CHECK.
  - CHECK (one cycle): verify that the XOR of data and parity is 1 and that stop is 1. Then decode the byte and return to IDLE.
- Decode (only when the frame is good):
  - 0xF0: set `brk`.
  - 0xE0: set `ext`.
  - Otherwise, if `brk` or `ext` is set, produce no output and clear both flags. This covers all release codes and all extended keys.
  - Otherwise, a letter make code loads `char` and pulses `char_valid`.
  - Otherwise, 0x5A pulses `enter`.
  - Any other byte is ignored.
- Letter map (code→letter): 1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M, 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z. Letters map to 1..26 in alphabetical order.
- Bad frame (parity error or stop bit 0): discard the byte, clear `brk` and `ext`, pulse `frame_err`.
- Watchdog:
  - The counter resets on every falling edge and counts only in SHIFT.
  - Reaching `TIMEOUT_CYCLES`-1 forces IDLE, clears the prefixes, and pulses `frame_err`.
  - The counter width is clog2(`TIMEOUT_CYCLES`).
- Reset: every output is 0, the state is IDLE, prefixes and shift register are cleared, and all synchroniser flops are set to 1 (idle bus). A reset asserted mid-frame discards the partial frame. No strobe is emitted on reset release.

## Timing
- Edge-detect latency: 3 `clk` cycles from a pin fall to the sampled bit.
- Output latency:
  - The strobe is asserted on the cycle after CHECK, i.e. 2 cycles after the stop-bit edge is detected.
  - `char` changes on the same cycle as `char_valid` rises.
- Strobe width:
  - Strobes are exactly 1 cycle.
  - `char_valid`, `enter` and `frame_err` are never asserted together.
- The consumer needs no handshake and cannot apply back-pressure. A new strobe can follow only after a full frame (≥11 PS/2 edges).
- Assumption: `clk` is at least 8× the PS/2 clock. Behaviour outside this is undefined.

## Configuration
- Macro `PS2_REPEAT_FILTER_EN` defined (filter on):
  - Typematic repeats are suppressed using a 5-bit `held` register.
  - A letter make code equal to `held` produces no `char_valid`. A new letter emits its strobe and loads `held`.
  - A break sequence (F0 + letter) whose letter equals `held` clears `held` to 0.
  - Enter is never filtered.
- Macro not defined (filter off): every letter make code, repeats included, pulses `char_valid`, and `held` is not implemented.

## Test plan
- Frame 0x1C with good parity → `char`=1 and `char_valid` high for 1 cycle, 2 cycles after the stop edge. `frame_err` stays 0.
- Sequence 1A, then F0, then 1A → a single `char_valid` with `char`=26. The release produces no output, and `char` stays 26.
- Frame 0x24 with even parity → `frame_err` pulse, no `char_valid`. A following good 0x24 → `char`=5.
- Stop after 5 data bits, wait `TIMEOUT_CYCLES` → one `frame_err` pulse, state returns to IDLE. A following good 0x15 → `char`=17.
- Sequence 5A → `enter` pulse. Sequence E0, 5A → no strobe. Reset asserted mid-frame of 0x1C → no strobe and all outputs 0.
- Sequence 1C, 1C, 1C, F0 1C, 1C → with `PS2_REPEAT_FILTER_EN`: 2 `char_valid` pulses. Without it: 4 pulses.
